// File: rtl/ts_serial_deser.sv
// rtl/ts_serial_deser.sv - serial MPEG-TS receiver: pin sync, bit deserialiser, packet alignment
// Bytes leave MSB-first aligned to SYNC_BYTE; sop/eop flag packet boundaries.
module ts_serial_deser #(
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE = 8'h47,
  parameter bit         SYNC_HUNT = 1'b1,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ts_clock,
  input  logic             ts_start,
  input  logic             ts_valid,
  input  logic             ts_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             locked,
  output logic             sync_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [7:0]       err_cnt
);

  localparam int BC_W = $clog2(PKT_LEN);

  typedef enum logic {S_HUNT, S_PKT} state_t;

  logic             r_clk_s1, r_clk_s2, r_clk_d;
  logic             r_start_s1, r_start_s2;
  logic             r_valid_s1, r_valid_s2;
  logic             r_data_s1, r_data_s2;
  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [BC_W-1:0]  r_byte_cnt;
  logic [7:0]       r_out_data;
  logic             r_out_valid, r_out_sop, r_out_eop, r_sync_err;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [7:0]       r_err_cnt;

  logic             w_rise, w_take, w_last_byte;
  logic [7:0]       w_window;
  state_t           w_state_nx;
  logic [7:0]       w_shift_nx;
  logic [2:0]       w_bit_cnt_nx;
  logic [BC_W-1:0]  w_byte_cnt_nx;
  logic             w_emit, w_sop, w_eop, w_err, w_pkt_inc;

  assign w_rise      = r_clk_s2 & ~r_clk_d;
  assign w_take      = w_rise & r_valid_s2 & enable;
  assign w_window    = {r_shift[6:0], r_data_s2};
  assign w_last_byte = (r_byte_cnt == BC_W'(PKT_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1    <= 1'b0;
      r_clk_s2    <= 1'b0;
      r_clk_d     <= 1'b0;
      r_start_s1  <= 1'b0;
      r_start_s2  <= 1'b0;
      r_valid_s1  <= 1'b0;
      r_valid_s2  <= 1'b0;
      r_data_s1   <= 1'b0;
      r_data_s2   <= 1'b0;
      r_state     <= S_HUNT;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= '0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_sync_err  <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= 8'h00;
    end else begin
      r_clk_s1    <= ts_clock;
      r_clk_s2    <= r_clk_s1;
      r_clk_d     <= r_clk_s2;
      r_start_s1  <= ts_start;
      r_start_s2  <= r_start_s1;
      r_valid_s1  <= ts_valid;
      r_valid_s2  <= r_valid_s1;
      r_data_s1   <= ts_data;
      r_data_s2   <= r_data_s1;
      r_state     <= w_state_nx;
      r_shift     <= w_shift_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_byte_cnt  <= w_byte_cnt_nx;
      r_out_valid <= w_emit;
      r_out_sop   <= w_sop;
      r_out_eop   <= w_eop;
      r_sync_err  <= w_err;
      if (w_emit) begin
        r_out_data <= w_window;
      end
      if (w_pkt_inc) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_bit_cnt_nx  = r_bit_cnt;
    w_byte_cnt_nx = r_byte_cnt;
    w_emit        = 1'b0;
    w_sop         = 1'b0;
    w_eop         = 1'b0;
    w_err         = 1'b0;
    w_pkt_inc     = 1'b0;
    if (!enable) begin
      w_state_nx    = S_HUNT;
      w_shift_nx    = 8'h00;
      w_bit_cnt_nx  = 3'd0;
      w_byte_cnt_nx = '0;
    end else if (w_take) begin
      case (r_state)
        S_HUNT: begin
          if (r_start_s2) begin
            w_state_nx    = S_PKT;
            w_shift_nx    = {7'd0, r_data_s2};
            w_bit_cnt_nx  = 3'd1;
            w_byte_cnt_nx = '0;
          end else if (SYNC_HUNT && (w_window == SYNC_BYTE)) begin
            // Sync found in the raw bit stream: it is byte 0, so emit it now.
            w_state_nx    = S_PKT;
            w_shift_nx    = w_window;
            w_emit        = 1'b1;
            w_sop         = 1'b1;
            w_bit_cnt_nx  = 3'd0;
            w_byte_cnt_nx = BC_W'(1);
          end else begin
            w_shift_nx = w_window;
          end
        end
        default: begin
          if (r_start_s2 && ((r_bit_cnt != 3'd0) || (r_byte_cnt != '0))) begin
            // Short packet: abandon it and treat this bit as the first of a new one.
            w_err         = 1'b1;
            w_shift_nx    = {7'd0, r_data_s2};
            w_bit_cnt_nx  = 3'd1;
            w_byte_cnt_nx = '0;
          end else begin
            w_shift_nx   = w_window;
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if ((r_byte_cnt == '0) && (w_window != SYNC_BYTE)) begin
                w_err         = 1'b1;
                w_state_nx    = S_HUNT;
                w_shift_nx    = 8'h00;
                w_bit_cnt_nx  = 3'd0;
                w_byte_cnt_nx = '0;
              end else begin
                w_emit = 1'b1;
                w_sop  = (r_byte_cnt == '0);
                w_eop  = w_last_byte;
                if (w_last_byte) begin
                  w_byte_cnt_nx = '0;
                  w_pkt_inc     = 1'b1;
                end else begin
                  w_byte_cnt_nx = r_byte_cnt + 1'b1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign locked    = (r_state == S_PKT);
  assign sync_err  = r_sync_err;
  assign pkt_cnt   = r_pkt_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
